// File: rtl/rtc_reg_arb.sv
// Round-robin arbiter sharing the RTC register bus between the CPU path (m0) and the sync/capture engine (m1).
// Optional slave-ack timeout with a `timeout` pulse port: define RTC_ARB_TIMEOUT_EN.
module rtc_reg_arb #(
    parameter int AW          = 5,
    parameter int DW          = 32,
`ifdef RTC_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 255,
`endif
    parameter int LOCK_MAX    = 4
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            m0_cs,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_be,
    input  logic            m0_wr,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    input  logic            m1_cs,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_be,
    input  logic            m1_wr,
    input  logic            m1_lock,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            s_cs,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_be,
    output logic            s_wr,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ack,
    output logic [1:0]      gnt,
    output logic            busy
`ifdef RTC_ARB_TIMEOUT_EN
    ,
    output logic            timeout
`endif
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t          state, state_nx;
    logic            rr_last, owner, lock_hold, lock_req;
    logic [CW-1:0]   lock_cnt;
    logic            grant_en, win, lock_clr, ack_ev, to_ev, locked;
    logic [DW-1:0]   rd_val;

`ifdef RTC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
`endif

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        win      = 1'b0;
        lock_clr = 1'b0;
        ack_ev   = 1'b0;
        to_ev    = 1'b0;
        rd_val   = s_rdata;
        locked   = lock_hold && (lock_cnt < CW'(LOCK_MAX));
        case (state)
            IDLE: begin
                if (locked && m1_cs) begin
                    grant_en = 1'b1;
                    win      = 1'b1;
                end else begin
                    // lock expires when exhausted or when m1 stops asking
                    lock_clr = lock_hold;
                    grant_en = m0_cs | m1_cs;
                    win      = (m0_cs && m1_cs) ? ~rr_last : m1_cs;
                end
                if (grant_en) state_nx = XFER;
            end
            XFER: begin
                if (s_ack) begin
                    ack_ev   = 1'b1;
                    state_nx = RESP;
                end
`ifdef RTC_ARB_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    to_ev    = 1'b1;
                    rd_val   = DW'(32'hDEAD_0BAD);
                    state_nx = RESP;
                end
`endif
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rr_last   <= 1'b1;
            owner     <= 1'b0;
            lock_hold <= 1'b0;
            lock_req  <= 1'b0;
            lock_cnt  <= '0;
            m0_rdata  <= '0;
            m0_ack    <= 1'b0;
            m1_rdata  <= '0;
            m1_ack    <= 1'b0;
            s_cs      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_be      <= '0;
            s_wr      <= 1'b0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            if (lock_clr) begin
                lock_hold <= 1'b0;
                lock_cnt  <= '0;
            end
            if (grant_en) begin
                owner   <= win;
                s_cs    <= 1'b1;
                gnt     <= win ? 2'b10 : 2'b01;
                busy    <= 1'b1;
                s_addr  <= win ? m1_addr  : m0_addr;
                s_wdata <= win ? m1_wdata : m0_wdata;
                s_be    <= win ? m1_be    : m0_be;
                s_wr    <= win ? m1_wr    : m0_wr;
            end
            if (ack_ev || to_ev) begin
                s_cs     <= 1'b0;
                lock_req <= owner & m1_lock;
                if (owner) begin
                    m1_rdata <= rd_val;
                    m1_ack   <= 1'b1;
                end else begin
                    m0_rdata <= rd_val;
                    m0_ack   <= 1'b1;
                end
            end
            if (state == RESP) begin
                rr_last <= owner;
                gnt     <= 2'b00;
                busy    <= 1'b0;
                if (lock_req) begin
                    lock_hold <= 1'b1;
                    lock_cnt  <= lock_cnt + 1'b1;
                end else begin
                    lock_hold <= 1'b0;
                    lock_cnt  <= '0;
                end
            end
        end
    end

`ifdef RTC_ARB_TIMEOUT_EN
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= (state == XFER) ? tcnt + 1'b1 : '0;
            timeout <= to_ev;
        end
    end
`endif

endmodule

// File: tb/tb_rtc_reg_arb.sv
// Bench for rtc_reg_arb: directed table/sequences plus random traffic against a phase-level reference model.
module tb_rtc_reg_arb;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int LM = 4;
`ifdef RTC_ARB_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          m0_cs, m0_wr, m0_ack, m1_cs, m1_wr, m1_lock, m1_ack;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic [BW-1:0] m0_be, m1_be, s_be;
    logic          s_cs, s_wr, s_ack, busy;
    logic [1:0]    gnt;
`ifdef RTC_ARB_TIMEOUT_EN
    logic          timeout;
`endif

    rtc_reg_arb #(
        .AW(AW), .DW(DW),
`ifdef RTC_ARB_TIMEOUT_EN
        .TIMEOUT_CYC(TO),
`endif
        .LOCK_MAX(LM)
    ) dut (
        .sys_clk(sys_clk), .rst(rst),
        .m0_cs(m0_cs), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_wr(m0_wr),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_cs(m1_cs), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_wr(m1_wr),
        .m1_lock(m1_lock), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_cs(s_cs), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_wr(s_wr),
        .s_rdata(s_rdata), .s_ack(s_ack), .gnt(gnt), .busy(busy)
`ifdef RTC_ARB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk, n_fail;

    // reference model: phase 0 idle, 1 slave access, 2 response
    int            ph, own, last, cnt, tcnt;
    bit            hold, lreq;
    logic          e_scs, e_wr, e_busy, e_to, e_ack0, e_ack1;
    logic [1:0]    e_gnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rd0, e_rd1;
    logic [BW-1:0] e_be;

    typedef struct {
        bit         c0;
        bit         c1;
        bit         lk;
        logic [1:0] g;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        ph = 0; own = 0; last = 1; cnt = 0; tcnt = 0; hold = 0; lreq = 0;
        e_scs = 0; e_wr = 0; e_busy = 0; e_to = 0; e_ack0 = 0; e_ack1 = 0;
        e_gnt = 0; e_addr = 0; e_wdata = 0; e_rd0 = 0; e_rd1 = 0; e_be = 0;
    endfunction

    function automatic void model_done(logic [DW-1:0] d);
        e_scs = 0;
        if (own == 1) begin e_rd1 = d; e_ack1 = 1; end
        else          begin e_rd0 = d; e_ack0 = 1; end
        lreq = (own == 1) && m1_lock;
        ph = 2;
    endfunction

    function automatic void model_step();
        int w;
        w = -1;
        if (rst) begin
            model_reset();
            return;
        end
        case (ph)
            0: begin
                if (hold && cnt < LM && m1_cs) w = 1;
                else begin
                    hold = 0; cnt = 0;
                    if (m0_cs && m1_cs) w = (last == 0) ? 1 : 0;
                    else if (m0_cs)     w = 0;
                    else if (m1_cs)     w = 1;
                end
                if (w >= 0) begin
                    own = w; ph = 1; tcnt = 0;
                    e_scs = 1; e_busy = 1;
                    e_gnt   = (w == 1) ? 2'b10 : 2'b01;
                    e_addr  = (w == 1) ? m1_addr  : m0_addr;
                    e_wdata = (w == 1) ? m1_wdata : m0_wdata;
                    e_be    = (w == 1) ? m1_be    : m0_be;
                    e_wr    = (w == 1) ? m1_wr    : m0_wr;
                end
            end
            1: begin
                if (s_ack) model_done(s_rdata);
`ifdef RTC_ARB_TIMEOUT_EN
                else if (tcnt == TO - 1) begin
                    model_done(32'hDEAD_0BAD);
                    e_to = 1;
                end else tcnt++;
`endif
            end
            default: begin
                e_ack0 = 0; e_ack1 = 0; e_to = 0;
                last = own;
                if (lreq) begin hold = 1; cnt++; end
                else begin hold = 0; cnt = 0; end
                e_gnt = 0; e_busy = 0; ph = 0;
            end
        endcase
    endfunction

    task automatic check_all();
        chk("s_cs",     32'(s_cs),    32'(e_scs));
        chk("gnt",      32'(gnt),     32'(e_gnt));
        chk("busy",     32'(busy),    32'(e_busy));
        chk("m0_ack",   32'(m0_ack),  32'(e_ack0));
        chk("m1_ack",   32'(m1_ack),  32'(e_ack1));
        chk("m0_rdata", m0_rdata,     e_rd0);
        chk("m1_rdata", m1_rdata,     e_rd1);
        chk("s_addr",   32'(s_addr),  32'(e_addr));
        chk("s_wdata",  s_wdata,      e_wdata);
        chk("s_be",     32'(s_be),    32'(e_be));
        chk("s_wr",     32'(s_wr),    32'(e_wr));
`ifdef RTC_ARB_TIMEOUT_EN
        chk("timeout",  32'(timeout), 32'(e_to));
`endif
    endtask

    // inputs are set between negedges; DUT samples them at the posedge in between
    task automatic step();
        model_step();
        @(negedge sys_clk);
        check_all();
    endtask

    task automatic wait_scs();
        for (int k = 0; k < 10 && s_cs !== 1'b1; k++) step();
        chk("wait_s_cs", 32'(s_cs), 32'd1);
    endtask

    task automatic run_vec(int i);
        m0_cs = tbl[i].c0; m1_cs = tbl[i].c1; m1_lock = tbl[i].lk;
        m0_addr = 5'(i);      m0_wdata = 32'hA000_0000 | 32'(i); m0_be = 4'h3; m0_wr = 1;
        m1_addr = 5'(i + 16); m1_wdata = 32'hB000_0000 | 32'(i); m1_be = 4'hC; m1_wr = 1;
        wait_scs();
        chk("vec_gnt",   32'(gnt), 32'(tbl[i].g));
        chk("vec_wdata", s_wdata, (tbl[i].g == 2'b10) ? m1_wdata : m0_wdata);
        chk("vec_be",    32'(s_be), (tbl[i].g == 2'b10) ? 32'h0C : 32'h03);
        repeat (i % 3) step();
        s_ack = 1; s_rdata = 32'h5000_0000 | 32'(i);
        step();
        s_ack = 0;
        chk("vec_ack", 32'({m1_ack, m0_ack}), 32'(tbl[i].g));
    endtask

    task automatic rand_req(int m);
        if (m == 0) begin
            m0_addr = 5'($urandom); m0_wdata = $urandom; m0_be = 4'($urandom); m0_wr = 1'($urandom);
        end else begin
            m1_addr = 5'($urandom); m1_wdata = $urandom; m1_be = 4'($urandom); m1_wr = 1'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0;
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 2'b01}, '{1'b1, 1'b1, 1'b0, 2'b10},
            '{1'b1, 1'b1, 1'b0, 2'b01}, '{1'b1, 1'b1, 1'b0, 2'b10},
            '{1'b1, 1'b1, 1'b0, 2'b01}, '{1'b1, 1'b1, 1'b0, 2'b10},
            '{1'b1, 1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 1'b1, 2'b10},
            '{1'b1, 1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 1'b1, 2'b10},
            '{1'b1, 1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 1'b1, 2'b01},
            '{1'b1, 1'b1, 1'b1, 2'b10}, '{1'b1, 1'b0, 1'b0, 2'b01},
            '{1'b1, 1'b1, 1'b0, 2'b10}, '{1'b0, 1'b1, 1'b1, 2'b10},
            '{1'b1, 1'b0, 1'b0, 2'b01}
        };
        rst = 1; s_ack = 0; s_rdata = 0; m1_lock = 0;
        m0_cs = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0; m0_wr = 0;
        m1_cs = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0; m1_wr = 0;
        model_reset();
        step(); step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_scs", 32'(s_cs), 32'd0);
        rst = 0;

        // single read, slave answers on the third access cycle
        m0_cs = 1; m0_addr = 5'h05; m0_wr = 0; m0_be = 4'hF;
        step();
        chk("rd_s_cs", 32'(s_cs), 32'd1);
        chk("rd_addr", 32'(s_addr), 32'h05);
        step(); step();
        s_ack = 1; s_rdata = 32'h0000_0123;
        step();
        s_ack = 0; m0_cs = 0;
        chk("rd_m0_ack", 32'(m0_ack), 32'd1);
        chk("rd_m0_rdata", m0_rdata, 32'h0000_0123);
        chk("rd_m1_ack", 32'(m1_ack), 32'd0);
        step();
        chk("rd_ack_pulse", 32'(m0_ack), 32'd0);

        // contention, lock run, lock release
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 17; i++) run_vec(i);
        m0_cs = 0; m1_cs = 0; m1_lock = 0;
        step(); step();

        // reset while the slave access is pending
        m0_cs = 1; m1_cs = 1;
        wait_scs();
        rst = 1;
        step();
        chk("rstx_scs",  32'(s_cs), 32'd0);
        chk("rstx_gnt",  32'(gnt), 32'd0);
        chk("rstx_busy", 32'(busy), 32'd0);
        chk("rstx_ack",  32'({m1_ack, m0_ack}), 32'd0);
        rst = 0;
        step();
        chk("rstx_first_gnt", 32'(gnt), 32'b01);
        s_ack = 1; s_rdata = 32'h1234_5678;
        step();
        s_ack = 0; m0_cs = 0; m1_cs = 0;
        step(); step();

`ifdef RTC_ARB_TIMEOUT_EN
        rst = 1; step(); rst = 0;
        m0_cs = 1; m0_wr = 0; m0_addr = 5'h07;
        wait_scs();
        repeat (TO - 1) step();
        chk("to_early", 32'(timeout), 32'd0);
        step();
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_ack", 32'(m0_ack), 32'd1);
        chk("to_rdata", m0_rdata, 32'hDEAD_0BAD);
        chk("to_scs", 32'(s_cs), 32'd0);
        m0_cs = 0; s_ack = 1;
        step();
        s_ack = 0;
        chk("to_late_ack", 32'(m0_ack), 32'd0);
        step();
`endif

        // random traffic with spurious acks, lock toggling and occasional reset
        for (int c = 0; c < 3000; c++) begin
            if (!m0_cs) begin
                if ($urandom_range(0, 2) == 0) begin m0_cs = 1; rand_req(0); end
            end else if (m0_ack) begin
                if ($urandom_range(0, 1) == 0) m0_cs = 0; else rand_req(0);
            end
            if (!m1_cs) begin
                if ($urandom_range(0, 2) == 0) begin m1_cs = 1; rand_req(1); end
            end else if (m1_ack) begin
                if ($urandom_range(0, 1) == 0) m1_cs = 0; else rand_req(1);
            end
            m1_lock = 1'($urandom);
            s_ack   = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            rst     = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_reg_arb.md
Name: rtc_reg_arb

Overview:
- Two-requester arbiter sharing the single RTC register bus (5-bit addr, 32-bit data, byte enables, cs/wr/ack) between:
  - the CPU register path (requester 0);
  - a hardware RTC sync/capture engine (requester 1).
- Round-robin arbitration, with a lock option so requester 1 can perform atomic multi-access sequences (capture, then time read, then date read).
- Sits in the system clock domain, in front of the async register bridge to the RTC core/reg block.

Parameters:
- AW, 5, register address width.
- DW, 32, data width.
- LOCK_MAX, 4, max consecutive locked transactions granted to requester 1 before a forced release.
- TIMEOUT_CYC, 255, slave-ack timeout in sys_clk cycles (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- m0_cs  in  1  requester 0 request; held until m0_ack.
- m0_addr  in  AW  requester 0 address.
- m0_wdata  in  DW  requester 0 write data.
- m0_be  in  DW/8  requester 0 byte enables.
- m0_wr  in  1  requester 0 write (1) / read (0).
- m0_rdata  out  DW  requester 0 read data.
- m0_ack  out  1  requester 0 completion pulse.
- m1_cs, m1_addr, m1_wdata, m1_be, m1_wr  in  1/AW/DW/DW/8/1  requester 1 request, same rules as requester 0.
- m1_lock  in  1  requester 1 asks to retain the grant after the current transaction.
- m1_rdata  out  DW  requester 1 read data.
- m1_ack  out  1  requester 1 completion pulse.
- s_cs  out  1  slave chip select.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_be  out  DW/8  slave byte enables.
- s_wr  out  1  slave write strobe.
- s_rdata  in  DW  slave read data, valid with s_ack.
- s_ack  in  1  slave completion pulse.
- gnt  out  2  one-hot current grant (bit0 = requester 0, bit1 = requester 1); 0 when idle.
- busy  out  1  a transaction is in flight.

Behaviour:
- Reset values (rst=1 at an edge): all outputs 0. Internal state: FSM=IDLE, rr_last=1 (requester 0 wins the first tie), lock_cnt=0.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - no cs → stay.
  - one cs → grant it.
  - both cs → grant the requester ≠ rr_last.
  - If LOCKED (lock_hold=1 and lock_cnt<LOCK_MAX), requester 1 is granted whenever m1_cs=1, regardless of m0_cs.
  - On grant, register the requester's addr/wdata/be/wr into s_*, set s_cs=1, gnt one-hot, busy=1; go to XFER.
  - Grant-to-s_cs latency: 1 cycle.
- XFER:
  - s_* held stable while s_cs=1.
  - On s_ack: s_cs=0, capture s_rdata into the granted requester's mX_rdata (writes also capture), pulse mX_ack for exactly 1 cycle, go to RESP.
  - Non-granted requester's ack stays 0; its rdata holds its last value.
- RESP (1 cycle, lets the master drop cs):
  - rr_last ← granted index.
  - If granted=1 and m1_lock=1 at the s_ack cycle: lock_hold=1 and lock_cnt+1; otherwise lock_hold=0 and lock_cnt=0.
  - gnt=0, busy=0, go to IDLE.
- Minimum cycles per transaction: 3 (IDLE→XFER→RESP) plus the slave latency.
- Back-to-back: a master keeping cs high after its ack is treated as a new request in the next IDLE. Fairness holds because rr_last alternates the winner.
- Lock boundaries:
  - When lock_cnt reaches LOCK_MAX, lock is ignored for the next arbitration: normal round-robin resumes and lock_cnt clears.
  - m1_cs low in IDLE while lock_hold=1 → lock_hold clears; requester 0 may be granted.
- Spurious s_ack in IDLE/RESP: ignored, no mX_ack.
- Reset mid-transaction: everything returns to reset values on the next edge; any outstanding master receives no ack.
- cs deasserted by a master before its ack: not supported; the transaction still completes and acks.

Optional Feature:
- Macro RTC_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit (clog2(TIMEOUT_CYC+1)) counter runs in XFER.
  - If TIMEOUT_CYC cycles elapse without s_ack: drop s_cs, return mX_rdata=32'hDEAD_0BAD with mX_ack pulse, and pulse added output port `timeout` (1 bit, reset 0) for 1 cycle, then go to RESP.
  - A late s_ack after timeout is ignored.
- Undefined: no counter and no `timeout` port; XFER waits indefinitely for s_ack.

Test Plan:
- Single read: m0 read addr 0x05, slave acks after 3 cycles with 0x0000_0123 → s_cs high 1 cycle after m0_cs, s_addr=0x05; m0_rdata=0x0000_0123 with one-cycle m0_ack; m1_ack stays 0.
- Contention: m0 and m1 hold cs continuously with writes, 6 transactions → gnt order 0,1,0,1,0,1; each write's s_wdata/s_be match its owner.
- Lock: m1_lock=1 with m0_cs constant and LOCK_MAX=4 → four consecutive m1 grants, then one m0 grant, then m1 again.
- Lock release: m1 locks once, then drops m1_cs in IDLE → the next grant goes to m0 immediately.
- Reset mid-XFER: assert rst during s_cs=1 → next cycle s_cs=0, gnt=0, busy=0, no acks; after release, m0 is granted first on a tie.
- With RTC_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: slave never acks → after 16 cycles timeout=1, m0_ack=1, m0_rdata=32'hDEAD_0BAD, s_cs=0.
